// File: rtl/feed_ctrl_pkg.sv
// Shared types and counter-width helpers for the systolic feed controller.
package feed_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } feed_state_t;

  function automatic int unsigned ld_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned cyc_w(input int unsigned dim, input int unsigned depth);
    return $clog2(depth + dim);
  endfunction

endpackage

// File: rtl/skew_mask.sv
// Maps the compute-cycle count to the diagonal lane enable window:
// lane i is active while i <= cyc < i + DEPTH.
module skew_mask import feed_ctrl_pkg::*; #(
  parameter int unsigned DIM   = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CycW = cyc_w(DIM, DEPTH)
) (
  input  logic [CycW-1:0] cyc_i,
  output logic [DIM-1:0]  mask_o
);

  int unsigned cyc_ext;

  always_comb begin
    cyc_ext = 32'(cyc_i);
    mask_o  = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      mask_o[i] = (cyc_ext >= i) && (cyc_ext < i + DEPTH);
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Load/compute sequencer for DIM skewed delay-buffer FIFOs feeding a systolic array.
// Define FEED_CTRL_PERF_EN to add the saturating busy-cycle counter perf_cycles_o.
module systolic_feed_ctrl import feed_ctrl_pkg::*; #(
  parameter int unsigned DIM   = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           load_valid_i,
  output logic           load_ready_o,
  output logic [DIM-1:0] fifo_en_o,
  output logic           fifo_zero_in_o,
  output logic [DIM-1:0] col_valid_o,
  output logic           busy_o,
  output logic           done_o
`ifdef FEED_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_cycles_o
`endif
);

  localparam int unsigned LdW  = ld_cnt_w(DEPTH);
  localparam int unsigned CycW = cyc_w(DIM, DEPTH);
  localparam logic [LdW-1:0]  LdLast  = LdW'(DEPTH - 1);
  localparam logic [CycW-1:0] CycLast = CycW'(DEPTH + DIM - 2);

  feed_state_t     state_q;
  logic [LdW-1:0]  ld_cnt_q;
  logic [CycW-1:0] cyc_q;
  logic            load_ready_q;
  logic            zero_in_q;
  logic            busy_q;
  logic            done_q;
  logic [DIM-1:0]  mask;

  skew_mask #(
    .DIM   (DIM),
    .DEPTH (DEPTH)
  ) u_skew_mask (
    .cyc_i  (cyc_q),
    .mask_o (mask)
  );

  // Flag outputs are registered alongside the state they decode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ld_cnt_q     <= '0;
      cyc_q        <= '0;
      load_ready_q <= 1'b0;
      zero_in_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q      <= LOAD;
            ld_cnt_q     <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid_i) begin
            ld_cnt_q <= ld_cnt_q + 1'b1;
            if (ld_cnt_q == LdLast) begin
              state_q      <= COMPUTE;
              cyc_q        <= '0;
              load_ready_q <= 1'b0;
              zero_in_q    <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          cyc_q <= cyc_q + 1'b1;
          if (cyc_q == CycLast) begin
            state_q   <= DONE;
            zero_in_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_en_o   = '0;
    col_valid_o = '0;
    unique case (state_q)
      LOAD:    fifo_en_o = {DIM{load_valid_i}};
      COMPUTE: begin
        fifo_en_o   = mask;
        col_valid_o = mask;
      end
      default: ;
    endcase
  end

  assign load_ready_o   = load_ready_q;
  assign fifo_zero_in_o = zero_in_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

`ifdef FEED_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      perf_q <= '0;
    end else if (busy_q && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule
